// File: rtl/radix_divider.sv
// Iterative restoring integer divider retiring BITS_PER_CYCLE quotient bits per clock.
// Signed operands are divided as magnitudes; signs are applied in a single fix-up cycle.
//
// state   | meaning
// IDLE    | results held, waiting for activate
// ITERATE | shift/compare/subtract, BITS_PER_CYCLE bits per edge
// FIXUP   | apply signs and flags, publish results, raise done
module radix_divider #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] leftOperand,
  input  logic [WIDTH-1:0] rightOperand,
  input  logic             isSigned,
  input  logic             activate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divisionByZero,
  output logic             overflow
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITERATE, FIXUP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             left_neg, right_neg;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      ovf_pend_q  <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_q      <= zero_d;
      ovf_pend_q  <= ovf_pend_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (activate) state_d = (rightOperand == '0) ? FIXUP : ITERATE;
      ITERATE: if (cnt_q == CNT_LAST) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;
    ovf_pend_d  = ovf_pend_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    left_neg    = isSigned & leftOperand[WIDTH-1];
    right_neg   = isSigned & rightOperand[WIDTH-1];
    step_rem    = rem_q;
    step_quo    = quo_q;
    case (state_q)
      IDLE: begin
        if (activate) begin
          zero_d     = (rightOperand == '0);
          // On a zero divisor the raw dividend rides in quo_q to become the remainder.
          quo_d      = (zero_d || !left_neg) ? leftOperand : -leftOperand;
          div_d      = right_neg ? -rightOperand : rightOperand;
          rem_d      = '0;
          cnt_d      = CNT_LOAD;
          neg_quo_d  = left_neg ^ right_neg;
          neg_rem_d  = left_neg;
          ovf_pend_d = isSigned && (leftOperand == SIGNED_MIN) && (rightOperand == '1);
          done_d     = 1'b0;
        end
      end
      ITERATE: begin
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
          step_rem = {step_rem[WIDTH-1:0], step_quo[WIDTH-1]};
          step_quo = {step_quo[WIDTH-2:0], 1'b0};
          if (step_rem >= {1'b0, div_q}) begin
            step_rem    = step_rem - {1'b0, div_q};
            step_quo[0] = 1'b1;
          end
        end
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_LAST;
      end
      FIXUP: begin
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = quo_q;
          dbz_d       = 1'b1;
          ovf_d       = 1'b0;
        end else begin
          quotient_d  = neg_quo_q ? -quo_q : quo_q;
          remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          dbz_d       = 1'b0;
          ovf_d       = ovf_pend_q;
        end
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy           = (state_q != IDLE);
    done           = done_q;
    quotient       = quotient_q;
    remainder      = remainder_q;
    divisionByZero = dbz_q;
    overflow       = ovf_q;
  end

endmodule

// File: tb/tb_radix_divider.sv
// Scoreboarded bench for radix_divider: three instances (32/B2, 32/B1, 16/B4) against a
// 64-bit arithmetic reference model.
module tb_radix_divider;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] lo0, ro0, q0, r0;
  logic        sg0, act0, busy0, done0, dbz0, ovf0;
  logic [31:0] lo1, ro1, q1, r1;
  logic        sg1, act1, busy1, done1, dbz1, ovf1;
  logic [15:0] lo2, ro2, q2, r2;
  logic        sg2, act2, busy2, done2, dbz2, ovf2;

  radix_divider #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_w32b2 (
    .clock(clock), .reset(reset), .leftOperand(lo0), .rightOperand(ro0), .isSigned(sg0),
    .activate(act0), .busy(busy0), .done(done0), .quotient(q0), .remainder(r0),
    .divisionByZero(dbz0), .overflow(ovf0));
  radix_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_w32b1 (
    .clock(clock), .reset(reset), .leftOperand(lo1), .rightOperand(ro1), .isSigned(sg1),
    .activate(act1), .busy(busy1), .done(done1), .quotient(q1), .remainder(r1),
    .divisionByZero(dbz1), .overflow(ovf1));
  radix_divider #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_w16b4 (
    .clock(clock), .reset(reset), .leftOperand(lo2), .rightOperand(ro2), .isSigned(sg2),
    .activate(act2), .busy(busy2), .done(done2), .quotient(q2), .remainder(r2),
    .divisionByZero(dbz2), .overflow(ovf2));

  typedef struct {
    int          idx;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cur   = 0;

  logic [31:0] obs_q, obs_r;
  logic        obs_busy, obs_done, obs_dbz, obs_ovf;

  always_comb begin
    obs_q = '0; obs_r = '0; obs_busy = 1'b0; obs_done = 1'b0; obs_dbz = 1'b0; obs_ovf = 1'b0;
    case (cur)
      0: begin obs_q = q0; obs_r = r0; obs_busy = busy0; obs_done = done0; obs_dbz = dbz0; obs_ovf = ovf0; end
      1: begin obs_q = q1; obs_r = r1; obs_busy = busy1; obs_done = done1; obs_dbz = dbz1; obs_ovf = ovf1; end
      default: begin
        obs_q = {16'd0, q2}; obs_r = {16'd0, r2}; obs_busy = busy2; obs_done = done2;
        obs_dbz = dbz2; obs_ovf = ovf2;
      end
    endcase
  end

  function automatic exp_t model(input int idx, input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
    exp_t   e;
    int     w, bpc;
    longint mask, ua, ub, sa, sbv, mn, q, r;
    w    = (idx == 2) ? 16 : 32;
    bpc  = (idx == 0) ? 2 : ((idx == 1) ? 1 : 4);
    mask = (longint'(1) << w) - 1;
    ua   = longint'({32'd0, a}) & mask;
    ub   = longint'({32'd0, b}) & mask;
    mn   = longint'(1) << (w - 1);
    e.idx = idx; e.dbz = 1'b0; e.ovf = 1'b0;
    q = 0; r = 0;
    if (ub == 0) begin
      e.q = 32'(mask); e.r = 32'(ua); e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.lat = w / bpc + 1;
      if (s) begin
        sa  = (ua >= mn) ? ua - (mask + 1) : ua;
        sbv = (ub >= mn) ? ub - (mask + 1) : ub;
        if (sa == -mn && sbv == -1) begin
          q = sa; r = 0; e.ovf = 1'b1;
        end else begin
          q = sa / sbv; r = sa % sbv;
        end
      end else begin
        q = ua / ub; r = ua % ub;
      end
      e.q = 32'(q & mask); e.r = 32'(r & mask);
    end
    return e;
  endfunction

  task automatic drive(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic act);
    cur = idx;
    case (idx)
      0: begin lo0 = a; ro0 = b; sg0 = s; act0 = act; end
      1: begin lo1 = a; ro1 = b; sg1 = s; act1 = act; end
      default: begin lo2 = a[15:0]; ro2 = b[15:0]; sg2 = s; act2 = act; end
    endcase
  endtask

  task automatic set_act(input int idx, input logic act);
    case (idx)
      0: act0 = act;
      1: act1 = act;
      default: act2 = act;
    endcase
  endtask

  // poke_at >= 0 issues a 5/10 request while busy, lat==poke_at samples after acceptance.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int poke_at);
    exp_t e;
    int   lat, busy_cnt;
    bit   seen;
    sb_q.push_back(model(idx, a, b, s));
    @(negedge clock);
    drive(idx, a, b, s, 1'b1);
    @(posedge clock); #1;
    set_act(idx, 1'b0);
    total++;
    if (obs_done !== 1'b0 || obs_busy !== 1'b1) begin
      bad++;
      $display("FAIL accept dut%0d busy=%b done=%b want busy=1 done=0", idx, obs_busy, obs_done);
    end
    busy_cnt = 1; lat = 0; seen = 0;
    while (!seen && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (poke_at >= 0 && lat == poke_at) drive(idx, 32'd5, 32'd10, s, 1'b1);
      if (poke_at >= 0 && lat == poke_at + 1) set_act(idx, 1'b0);
      if (obs_done === 1'b1) seen = 1;
      else if (obs_busy === 1'b1) busy_cnt++;
    end
    set_act(idx, 1'b0);
    e = sb_q.pop_front();
    total++;
    if (!seen || lat != e.lat) begin
      bad++;
      $display("FAIL latency dut%0d a=%h b=%h got=%0d want=%0d", idx, a, b, lat, e.lat);
    end
    total++;
    if (busy_cnt != e.lat || obs_busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_len dut%0d got=%0d want=%0d busy_at_done=%b", idx, busy_cnt, e.lat, obs_busy);
    end
    total++;
    if (obs_q !== e.q || obs_r !== e.r) begin
      bad++;
      $display("FAIL result dut%0d a=%h b=%h s=%b q=%h r=%h want q=%h r=%h",
               idx, a, b, s, obs_q, obs_r, e.q, e.r);
    end
    total++;
    if (obs_dbz !== e.dbz || obs_ovf !== e.ovf) begin
      bad++;
      $display("FAIL flags dut%0d a=%h b=%h dbz=%b ovf=%b want dbz=%b ovf=%b",
               idx, a, b, obs_dbz, obs_ovf, e.dbz, e.ovf);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(2, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      cur = i; #0;
      total++;
      if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_q !== 32'd0 || obs_r !== 32'd0 ||
          obs_dbz !== 1'b0 || obs_ovf !== 1'b0) begin
        bad++;
        $display("FAIL reset dut%0d busy=%b done=%b q=%h r=%h dbz=%b ovf=%b want all 0",
                 i, obs_busy, obs_done, obs_q, obs_r, obs_dbz, obs_ovf);
      end
    end
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b1;
  endtask

  task automatic test_unsigned_b2;
    run_op(0, 32'd25, 32'd4, 1'b0, -1);
    repeat (20) @(posedge clock);
    #1;
    total++;
    if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_q !== 32'd6 || obs_r !== 32'd1) begin
      bad++;
      $display("FAIL hold done=%b busy=%b q=%h r=%h want done=1 busy=0 q=6 r=1",
               obs_done, obs_busy, obs_q, obs_r);
    end
  endtask

  task automatic test_signed_b2;
    run_op(0, 32'hFFFF_FFF9, 32'd3, 1'b1, -1);
    run_op(0, 32'd7, 32'hFFFF_FFFD, 1'b1, -1);
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
  endtask

  task automatic test_div_zero_b1;
    run_op(1, 32'd1, 32'd0, 1'b1, -1);
    run_op(1, 32'd1, 32'd0, 1'b0, -1);
    run_op(1, 32'd1, 32'd1, 1'b0, -1);
  endtask

  task automatic test_w16_b4;
    run_op(2, 32'h0000_8000, 32'd3, 1'b1, -1);
    run_op(2, 32'h0000_9999, 32'h0000_3333, 1'b0, -1);
    run_op(2, 32'h0000_8000, 32'h0000_FFFF, 1'b1, -1);
  endtask

  task automatic test_ignore_busy;
    run_op(1, 32'h9999_999A, 32'd3, 1'b0, 5);
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    drive(1, 32'h9999_999A, 32'd3, 1'b0, 1'b1);
    @(posedge clock); #1;
    set_act(1, 1'b0);
    repeat (10) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    total++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || q1 !== 32'd0 || r1 !== 32'd0 ||
        dbz1 !== 1'b0 || ovf1 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset busy=%b done=%b q=%h r=%h dbz=%b ovf=%b want all 0",
               busy1, done1, q1, r1, dbz1, ovf1);
    end
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    run_op(1, 32'd100, 32'd10, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    int   n, done_cnt;
    bit   seen;
    exp_t e;
    sb_q.push_back(model(0, 32'd25, 32'd4, 1'b0));
    sb_q.push_back(model(0, 32'd25, 32'd4, 1'b0));
    @(negedge clock);
    drive(0, 32'd25, 32'd4, 1'b0, 1'b1);
    @(posedge clock); #1;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (done0 === 1'b1) seen = 1;
    end
    e = sb_q.pop_front();
    total++;
    if (!seen || q0 !== e.q || r0 !== e.r) begin
      bad++;
      $display("FAIL b2b_first seen=%0d q=%h r=%h want q=%h r=%h", seen, q0, r0, e.q, e.r);
    end
    done_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (done0 === 1'b1) done_cnt++;
    end
    total++;
    if (done_cnt != 1 || busy0 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done_pulse done_cycles=%0d busy=%b want 1 cycle and busy=1", done_cnt, busy0);
    end
    act0 = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (done0 === 1'b1) seen = 1;
    end
    e = sb_q.pop_front();
    total++;
    if (!seen || q0 !== e.q || r0 !== e.r || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second seen=%0d q=%h r=%h busy=%b want q=%h r=%h busy=0",
               seen, q0, r0, busy0, e.q, e.r);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 18; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      run_op(i % 3, a, b, s, -1);
    end
  endtask

  initial begin
    test_reset;
    test_unsigned_b2;
    test_signed_b2;
    test_div_zero_b1;
    test_w16_b4;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
